// File: rtl/mul_seq.sv
// ============================================================================
// Module   : mul_seq
// Purpose  : Iterative signed multiplier with valid/ready on both sides; the
//            MUL_SEQ_SAT_EN macro saturates overflowing results instead of
//            letting them wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq #(
    parameter int ARG_WIDTH      = 32,
    parameter int RES_WIDTH      = ARG_WIDTH * 2,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arg_vld,
    output logic                 arg_rdy,
    input  logic [ARG_WIDTH-1:0] a,
    input  logic [ARG_WIDTH-1:0] b,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [RES_WIDTH-1:0] res,
    output logic                 overflow,
    output logic                 busy
);

    localparam int ITER  = ARG_WIDTH / BITS_PER_CYCLE;
    localparam int PW    = 2 * ARG_WIDTH;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    if (RES_WIDTH < 2 || RES_WIDTH > 2 * ARG_WIDTH) begin : g_bad_res_width
        $error("mul_seq: RES_WIDTH must lie in 2..2*ARG_WIDTH");
    end
    if (BITS_PER_CYCLE < 1 || (ARG_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("mul_seq: BITS_PER_CYCLE must divide ARG_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sign;
    logic [PW-1:0]          r_mcand;
    logic [ARG_WIDTH-1:0]   r_mag_b;
    logic [PW-1:0]          r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [RES_WIDTH-1:0]   r_res;
    logic                   r_ovf;

    logic                   w_accept;
    logic                   w_last;
    logic [ARG_WIDTH-1:0]   w_mag_a;
    logic [ARG_WIDTH-1:0]   w_mag_b;
    logic [PW-1:0]          w_pp;
    logic [PW-1:0]          w_acc_nxt;
    logic [PW-1:0]          w_prod;
    logic [PW-RES_WIDTH:0]  w_hi;
    logic                   w_ovf;
    logic [RES_WIDTH-1:0]   w_res;

    assign arg_rdy  = (r_state == S_IDLE) || (r_state == S_DONE && res_rdy);
    assign w_accept = arg_vld && arg_rdy;
    assign w_last   = (r_cnt == CNT_W'(ITER - 1));
    assign res_vld  = (r_state == S_DONE);
    assign busy     = (r_state == S_BUSY);
    assign res      = r_res;
    assign overflow = r_ovf;

    // Negating the most negative operand yields 2^(N-1), still exact as unsigned.
    assign w_mag_a = a[ARG_WIDTH-1] ? -a : a;
    assign w_mag_b = b[ARG_WIDTH-1] ? -b : b;

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mag_b[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    assign w_acc_nxt = r_acc + w_pp;
    assign w_prod    = r_sign ? -w_acc_nxt : w_acc_nxt;

    // The product fits iff every bit from RES_WIDTH-1 upward is a sign copy.
    assign w_hi  = w_prod[PW-1:RES_WIDTH-1];
    assign w_ovf = !((&w_hi) || !(|w_hi));

`ifdef MUL_SEQ_SAT_EN
    localparam logic [RES_WIDTH-1:0] RES_MAX = {1'b0, {(RES_WIDTH-1){1'b1}}};
    localparam logic [RES_WIDTH-1:0] RES_MIN = {1'b1, {(RES_WIDTH-1){1'b0}}};
    assign w_res = w_ovf ? (w_prod[PW-1] ? RES_MIN : RES_MAX) : w_prod[RES_WIDTH-1:0];
`else
    assign w_res = w_prod[RES_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY: if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                end else if (res_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign  <= 1'b0;
            r_mcand <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_sign  <= a[ARG_WIDTH-1] ^ b[ARG_WIDTH-1];
            r_mcand <= PW'(w_mag_a);
            r_mag_b <= w_mag_b;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << BITS_PER_CYCLE;
            r_mag_b <= r_mag_b >> BITS_PER_CYCLE;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_res <= w_res;
                r_ovf <= w_ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// ============================================================================
// Module   : tb_mul_seq
// Purpose  : Self-checking bench for mul_seq (ARG_WIDTH=8, BITS_PER_CYCLE=2),
//            RES_WIDTH=8 and RES_WIDTH=16 instances driven in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq;

`ifdef MUL_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arg_vld = 1'b0;
    logic        res_rdy = 1'b1;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;

    logic        arg_rdy8, res_vld8, ovf8, busy8;
    logic [7:0]  res8;
    logic        arg_rdy16, res_vld16, ovf16, busy16;
    logic [15:0] res16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_seq #(.ARG_WIDTH(8), .RES_WIDTH(8), .BITS_PER_CYCLE(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy8),
        .a(a), .b(b), .res_vld(res_vld8), .res_rdy(res_rdy), .res(res8),
        .overflow(ovf8), .busy(busy8)
    );

    mul_seq #(.ARG_WIDTH(8), .RES_WIDTH(16), .BITS_PER_CYCLE(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy16),
        .a(a), .b(b), .res_vld(res_vld16), .res_rdy(res_rdy), .res(res16),
        .overflow(ovf16), .busy(busy16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  r8_wrap;
        logic [7:0]  r8_sat;
        logic        o8;
        logic [15:0] r16;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer product, then range test / wrap / clamp.
    function automatic void model(input logic [7:0] x, input logic [7:0] y, input int rw,
                                  output logic [15:0] r, output logic o);
        longint p, mx, mn;
        p  = longint'($signed(x)) * longint'($signed(y));
        mx = (longint'(1) <<< (rw - 1)) - 1;
        mn = -mx - 1;
        o  = (p > mx) || (p < mn);
        if (o && SAT) p = (p > 0) ? mx : mn;
        r  = p[15:0];
    endfunction

    task automatic wait_res(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!res_vld8 && n < 20);
        if (!res_vld8) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: res_vld got 0 expected 1 after %0d cycles", n);
        end
    endtask

    task automatic check_res(input logic [7:0] e8, input logic eo8, input logic [15:0] e16);
        check("res8", 32'(res8), 32'(e8));
        check("ovf8", 32'(ovf8), 32'(eo8));
        check("res16", 32'(res16), 32'(e16));
        check("ovf16", 32'(ovf16), 32'd0);
        check("res_vld16", 32'(res_vld16), 32'd1);
    endtask

    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] e8, input logic eo8, input logic [15:0] e16);
        int n;
        @(negedge clk);
        a = x; b = y; arg_vld = 1'b1; res_rdy = 1'b1;
        check("arg_rdy_idle", 32'(arg_rdy8), 32'd1);
        @(posedge clk); #1;
        arg_vld = 1'b0;
        check("busy_after_accept", 32'(busy8), 32'd1);
        wait_res(n);
        check("latency", 32'(n), 32'd4);
        check_res(e8, eo8, e16);
        @(posedge clk); #1;
        check("res_vld_one_cycle", 32'(res_vld8), 32'd0);
        check("res_held_idle", 32'(res8), 32'(e8));
    endtask

    vec_t vecs[13];

    initial begin
        logic [15:0] m8, m16;
        logic        mo8, mo16;
        logic [7:0]  sa[4], sb[4];
        int          n;

        vecs[0]  = '{8'd7,    8'hFD, 8'hEB, 8'hEB, 1'b0, 16'hFFEB};
        vecs[1]  = '{8'd16,   8'd16, 8'h00, 8'h7F, 1'b1, 16'h0100};
        vecs[2]  = '{8'hF0,   8'd9,  8'h70, 8'h80, 1'b1, 16'hFF70};
        vecs[3]  = '{8'h80,   8'd1,  8'h80, 8'h80, 1'b0, 16'hFF80};
        vecs[4]  = '{8'h80,   8'h80, 8'h00, 8'h7F, 1'b1, 16'h4000};
        vecs[5]  = '{8'd3,    8'd5,  8'h0F, 8'h0F, 1'b0, 16'h000F};
        vecs[6]  = '{8'd0,    8'h80, 8'h00, 8'h00, 1'b0, 16'h0000};
        vecs[7]  = '{8'hFF,   8'hFF, 8'h01, 8'h01, 1'b0, 16'h0001};
        vecs[8]  = '{8'd127,  8'd127, 8'h01, 8'h7F, 1'b1, 16'h3F01};
        vecs[9]  = '{8'h80,   8'd127, 8'h80, 8'h80, 1'b1, 16'hC080};
        vecs[10] = '{8'd11,   8'hF5, 8'h87, 8'h87, 1'b0, 16'hFF87};
        vecs[11] = '{8'hF0,   8'd8,  8'h80, 8'h80, 1'b0, 16'hFF80};
        vecs[12] = '{8'd8,    8'd16, 8'h80, 8'h7F, 1'b1, 16'h0080};

        // Reset state, with operands offered that must not be captured.
        arg_vld = 1'b1; a = 8'd9; b = 8'd9;
        #3;
        check("rst_arg_rdy", 32'(arg_rdy8), 32'd1);
        check("rst_res_vld", 32'(res_vld8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_res", 32'(res8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_capture", 32'(busy8), 32'd0);
        arg_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].a, vecs[i].b, SAT ? vecs[i].r8_sat : vecs[i].r8_wrap,
                  vecs[i].o8, vecs[i].r16);
        end

        for (int i = 0; i < 30; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom);
            y = 8'($urandom);
            model(x, y, 8, m8, mo8);
            model(x, y, 16, m16, mo16);
            do_op(x, y, m8[7:0], mo8, m16);
            check("ovf16_model", 32'(ovf16), 32'(mo16));
        end

        // Backpressure: result held, new operands refused until res_rdy rises.
        @(negedge clk);
        a = 8'd16; b = 8'd16; arg_vld = 1'b1; res_rdy = 1'b0;
        @(posedge clk); #1;
        a = 8'hFB; b = 8'd6;
        wait_res(n);
        check("bp_latency", 32'(n), 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp_res", 32'(res8), SAT ? 32'h7F : 32'h00);
            check("bp_ovf", 32'(ovf8), 32'd1);
            check("bp_arg_rdy", 32'(arg_rdy8), 32'd0);
            check("bp_res_vld", 32'(res_vld8), 32'd1);
            @(posedge clk); #1;
        end
        res_rdy = 1'b1;
        #1;
        check("bp_arg_rdy_release", 32'(arg_rdy8), 32'd1);
        @(posedge clk); #1;
        arg_vld = 1'b0;
        check("bp_accept_busy", 32'(busy8), 32'd1);
        wait_res(n);
        check("bp_latency2", 32'(n), 32'd4);
        check_res(8'hE2, 1'b0, 16'hFFE2);

        // Streaming: each new op accepted in the DONE cycle of the previous one.
        @(posedge clk); #1;
        sa = '{8'd5, 8'hF9, 8'd100, 8'h80};
        sb = '{8'd6, 8'd13, 8'hFE, 8'hFF};
        @(negedge clk);
        a = sa[0]; b = sb[0]; arg_vld = 1'b1; res_rdy = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            wait_res(n);
            check("stream_spacing", 32'(n), (k == 0) ? 32'd4 : 32'd5);
            model(sa[k], sb[k], 8, m8, mo8);
            model(sa[k], sb[k], 16, m16, mo16);
            check_res(m8[7:0], mo8, m16);
            if (k < 3) begin
                a = sa[k+1]; b = sb[k+1];
            end else begin
                arg_vld = 1'b0;
            end
        end

        // Reset in the middle of BUSY discards the operation.
        @(negedge clk);
        a = 8'd100; b = 8'hF9; arg_vld = 1'b1; res_rdy = 1'b1;
        @(posedge clk); #1;
        arg_vld = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_vld", 32'(res_vld8), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_res", 32'(res8), 32'd0);
        check("mid_rst_ovf", 32'(ovf8), 32'd0);
        check("mid_rst_res16", 32'(res16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_result", 32'(res_vld8), 32'd0);
        check("post_rst_arg_rdy", 32'(arg_rdy8), 32'd1);
        do_op(8'd3, 8'd5, 8'h0F, 1'b0, 16'h000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Iterative signed multiplier: multi-cycle, parametrised successor of the team's combinational signed multiplier.
- Adds valid/ready handshakes on both sides, a configurable number of multiplier bits retired per cycle, and registered overflow detection against a narrower result width.
- Sits in datapaths where a full ARG_WIDTH x ARG_WIDTH array multiplier is too large and fixed multi-cycle latency is acceptable.

Parameters:
- ARG_WIDTH, 32, width of signed operands a and b.
- RES_WIDTH, ARG_WIDTH*2, width of signed result. Legal range 2..2*ARG_WIDTH; any other value is an elaboration error.
- BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle. Must divide ARG_WIDTH, else elaboration error.
- ITER (localparam), ARG_WIDTH/BITS_PER_CYCLE, number of BUSY cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- arg_vld  input  1  operands valid.
- arg_rdy  output  1  block can accept operands.
- a  input  ARG_WIDTH  signed multiplicand.
- b  input  ARG_WIDTH  signed multiplier.
- res_vld  output  1  result valid.
- res_rdy  input  1  downstream accepts result.
- res  output  RES_WIDTH  signed result.
- overflow  output  1  exact product not representable in RES_WIDTH signed; qualified by res_vld.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, res=0, overflow=0, res_vld=0, busy=0, internal accumulator/counter=0.
  - arg_rdy reads 1 (IDLE), but nothing is captured while rst_n is low.
  - Reset during BUSY or DONE discards the operation; no partial result is ever presented.
- States: IDLE, BUSY, DONE.
- Accept condition: arg_vld && arg_rdy at a rising edge.
  - arg_rdy = (state==IDLE) || (state==DONE && res_rdy). This is a combinational path res_rdy -> arg_rdy, by design.
- On accept:
  - Register sign = a[MSB]^b[MSB].
  - Register magnitudes |a|, |b| as ARG_WIDTH-bit unsigned; -2^(ARG_WIDTH-1) maps to 2^(ARG_WIDTH-1) without loss.
  - Clear the 2*ARG_WIDTH-bit accumulator, set counter=0, go to BUSY.
- BUSY: each cycle retires BITS_PER_CYCLE low bits of |b| with shift-add into the accumulator, then increments the counter.
  - Latency is fixed at ITER cycles regardless of operand values, zeros included.
  - arg_vld is ignored in BUSY.
- Last BUSY edge (counter==ITER-1):
  - Form the exact signed product P (2*ARG_WIDTH bits), negated if sign=1.
  - Register overflow = (P < -2^(RES_WIDTH-1)) || (P > 2^(RES_WIDTH-1)-1).
  - Register res (see Optional Feature).
  - Go to DONE; res_vld=1.
  - res_vld therefore rises exactly ITER cycles after the accepting edge.
- DONE:
  - res and overflow stay stable while res_vld && !res_rdy (unbounded backpressure).
  - On res_rdy with no new accept: go to IDLE, res_vld=0. res and overflow keep their last values.
  - On res_rdy with arg_vld in the same cycle: accept the new operands and go directly to BUSY. Throughput is one op per ITER+1 cycles.
- RES_WIDTH=2*ARG_WIDTH: overflow is never set, including (-2^(N-1)) * (-2^(N-1)) = 2^(2N-2).
- busy=1 only in BUSY.

Optional Feature:
- Macro: MUL_SEQ_SAT_EN.
- Defined: when overflow=1, res saturates to 2^(RES_WIDTH-1)-1 if P>0, or -2^(RES_WIDTH-1) if P<0. The overflow flag is still reported.
- Undefined: res = P[RES_WIDTH-1:0] (two's-complement wrap), with overflow reported.
- Non-overflow results are identical in both builds.

Test Plan:
Configuration for all cases: ARG_WIDTH=8, BITS_PER_CYCLE=2, ITER=4, RES_WIDTH=8 unless stated.
1. a=7, b=-3, res_rdy=1 -> res=0xEB (-21), overflow=0. res_vld high exactly 4 cycles after the accept edge, for 1 cycle.
2. a=16, b=16 -> overflow=1. res=0x00 without the macro; res=0x7F with MUL_SEQ_SAT_EN.
   a=-16, b=9 -> overflow=1; res=0x70 wrapped, 0x80 saturated.
3. a=-128, b=1 -> res=0x80, overflow=0.
   a=-128, b=-128 with RES_WIDTH=16 -> res=0x4000, overflow=0.
   Same operands with RES_WIDTH=8 -> overflow=1; res=0x00 wrapped, 0x7F saturated.
4. Complete an op, hold res_rdy=0 for 10 cycles while driving arg_vld=1 with new operands -> res and overflow unchanged, arg_rdy=0, nothing accepted. Raise res_rdy -> new operands accepted that edge.
5. Stream 4 ops with arg_vld=1 and res_rdy=1 continuously -> each accepted in the DONE cycle of the previous op, one result every 5 cycles, all values correct.
6. Assert rst_n=0 at BUSY cycle 2 -> res_vld, res, overflow, busy go 0 immediately. After release: arg_rdy=1, no stale result; next op a=3, b=5 gives res=15.
